// File: rtl/ps2_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ps2_game_ctrl
// Description : PS/2 set-2 scancode decoder that drives game controls
//               (left/right levels, rate-limited fire pulse, pause toggle).
//               Optional feature macro: ARROW_KEYS_EN (arrow keys also steer).
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_game_ctrl #(
    parameter int unsigned FIRE_COOLDOWN = 250000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] ps2_key_data,
    input  logic       ps2_key_pressed,
    output logic       move_left,
    output logic       move_right,
    output logic       fire,
    output logic       pause
);

    localparam logic [7:0]  c_code_ext   = 8'hE0;
    localparam logic [7:0]  c_code_brk   = 8'hF0;
    localparam logic [7:0]  c_code_a     = 8'h1C;
    localparam logic [7:0]  c_code_d     = 8'h23;
    localparam logic [7:0]  c_code_space = 8'h29;
    localparam logic [7:0]  c_code_p     = 8'h4D;
`ifdef ARROW_KEYS_EN
    localparam logic [7:0]  c_code_larr  = 8'h6B;
    localparam logic [7:0]  c_code_rarr  = 8'h74;
`endif
    localparam logic [20:0] c_cool_load  = 21'(FIRE_COOLDOWN);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        a_held_q, a_held_d;
    logic        d_held_q, d_held_d;
    logic        space_held_q, space_held_d;
    logic        p_held_q, p_held_d;
`ifdef ARROW_KEYS_EN
    logic        larr_held_q, larr_held_d;
    logic        rarr_held_q, rarr_held_d;
`endif
    logic [20:0] cooldown_q, cooldown_d;
    logic        move_left_q, move_left_d;
    logic        move_right_q, move_right_d;
    logic        fire_q, fire_d;
    logic        pause_q, pause_d;

    logic        is_ext;
    logic        is_make;
    logic        left_held;
    logic        right_held;

    always_comb begin
        state_d      = state_q;
        a_held_d     = a_held_q;
        d_held_d     = d_held_q;
        space_held_d = space_held_q;
        p_held_d     = p_held_q;
`ifdef ARROW_KEYS_EN
        larr_held_d  = larr_held_q;
        rarr_held_d  = rarr_held_q;
`endif
        fire_d       = 1'b0;
        pause_d      = pause_q;
        cooldown_d   = (cooldown_q != 21'd0) ? (cooldown_q - 21'd1) : 21'd0;
        is_ext       = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        is_make      = (state_q == ST_IDLE) || (state_q == ST_EXT);

        if (ps2_key_pressed) begin
            if (ps2_key_data == c_code_ext) begin
                state_d = ST_EXT;
            end else if (ps2_key_data == c_code_brk) begin
                state_d = is_ext ? ST_EXT_BRK : ST_BRK;
            end else begin
                // Any non-prefix byte ends the sequence, mapped or not.
                state_d = ST_IDLE;
                if (!is_ext) begin
                    case (ps2_key_data)
                        c_code_a: a_held_d = is_make;
                        c_code_d: d_held_d = is_make;
                        c_code_space: begin
                            if (is_make && !space_held_q && !pause_q &&
                                (cooldown_q == 21'd0)) begin
                                fire_d = 1'b1;
                            end
                            space_held_d = is_make;
                        end
                        c_code_p: begin
                            if (is_make && !p_held_q) begin
                                pause_d = !pause_q;
                            end
                            p_held_d = is_make;
                        end
                        default: ;
                    endcase
                end
`ifdef ARROW_KEYS_EN
                else begin
                    case (ps2_key_data)
                        c_code_larr: larr_held_d = is_make;
                        c_code_rarr: rarr_held_d = is_make;
                        default: ;
                    endcase
                end
`endif
            end
        end

        if (fire_d) begin
            cooldown_d = c_cool_load;
        end

`ifdef ARROW_KEYS_EN
        left_held  = a_held_d | larr_held_d;
        right_held = d_held_d | rarr_held_d;
`else
        left_held  = a_held_d;
        right_held = d_held_d;
`endif
        // Outputs are computed from next-state values so they register once.
        move_left_d  = left_held & ~right_held & ~pause_d;
        move_right_d = right_held & ~left_held & ~pause_d;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q      <= ST_IDLE;
            a_held_q     <= 1'b0;
            d_held_q     <= 1'b0;
            space_held_q <= 1'b0;
            p_held_q     <= 1'b0;
`ifdef ARROW_KEYS_EN
            larr_held_q  <= 1'b0;
            rarr_held_q  <= 1'b0;
`endif
            cooldown_q   <= 21'd0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
            fire_q       <= 1'b0;
            pause_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_held_q     <= a_held_d;
            d_held_q     <= d_held_d;
            space_held_q <= space_held_d;
            p_held_q     <= p_held_d;
`ifdef ARROW_KEYS_EN
            larr_held_q  <= larr_held_d;
            rarr_held_q  <= rarr_held_d;
`endif
            cooldown_q   <= cooldown_d;
            move_left_q  <= move_left_d;
            move_right_q <= move_right_d;
            fire_q       <= fire_d;
            pause_q      <= pause_d;
        end
    end

    assign move_left  = move_left_q;
    assign move_right = move_right_q;
    assign fire       = fire_q;
    assign pause      = pause_q;

endmodule
`default_nettype wire

// File: doc/ps2_game_ctrl.md
PS2_GAME_CTRL -- requirements
Module: ps2_game_ctrl

Interface
REQ-001 SHALL have parameter FIRE_COOLDOWN, default 250000, meaning the minimum number of iCLK cycles from one fire pulse to the next; legal range 1..2^21-1.
REQ-002 SHALL have port iCLK, input, 1 bit: the single clock; all state is on its rising edge.
REQ-003 SHALL have port iRST, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port ps2_key_data, input, 8 bits: received scancode byte (PS/2 set 2).
REQ-005 SHALL have port ps2_key_pressed, input, 1 bit: one-cycle strobe; ps2_key_data is valid in that cycle.
REQ-006 SHALL have port move_left, output, 1 bit: level, high while left is held.
REQ-007 SHALL have port move_right, output, 1 bit: level, high while right is held.
REQ-008 SHALL have port fire, output, 1 bit: one-cycle pulse per accepted fire press.
REQ-009 SHALL have port pause, output, 1 bit: toggled level.

Function
REQ-010 SHALL decode bytes with a 4-state FSM: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
REQ-011 SHALL apply these prefix transitions on a strobed byte: E0 -> EXT from any state; F0 -> BRK from IDLE or BRK; F0 -> EXT_BRK from EXT or EXT_BRK.
REQ-012 SHALL treat any other strobed byte as terminating: apply it as a make (IDLE/EXT) or a break (BRK/EXT_BRK), then return to IDLE.
REQ-013 SHALL map non-extended keys as: 1C (A) = left, 23 (D) = right, 29 (Space) = fire, 4D (P) = pause.
REQ-014 SHALL ignore unmapped codes (including AA, FA, EE), with the FSM still returning to IDLE.
REQ-015 SHALL keep an independent held flag per mapped physical key: a make sets it and a break clears it.
REQ-016 SHALL drive move_left = left-held AND NOT right-held AND NOT pause; move_right is symmetric, so both keys held gives both outputs 0.
REQ-017 SHALL pulse fire only on a Space make while Space is not already held (typematic repeats ignored), pause = 0, and the cooldown counter = 0.
REQ-018 SHALL discard a fire press that is rejected by REQ-017; it is never queued.
REQ-019 SHALL load the 21-bit cooldown counter with FIRE_COOLDOWN on each fire pulse, decrement it by 1 per cycle while nonzero, and saturate at 0.
REQ-020 SHALL toggle pause on a P make while P is not already held; typematic repeats of P are ignored.
REQ-021 SHALL register all outputs: a strobe in cycle N affects outputs in cycle N+1.
REQ-022 SHALL ignore ps2_key_data in cycles where ps2_key_pressed is 0.
REQ-023 SHALL keep held flags updating while paused, so releases during pause are tracked.

Reset
REQ-024 SHALL on iRST = 1 asynchronously force FSM = IDLE, all held flags = 0, cooldown counter = 0, and move_left = move_right = fire = pause = 0.
REQ-025 SHALL drop bytes strobed during reset; a prefix sequence interrupted by reset restarts from IDLE.

Configuration
REQ-026 SHALL, with macro ARROW_KEYS_EN defined, map E0 6B (left arrow) = left and E0 74 (right arrow) = right in EXT/EXT_BRK, each with its own held flag; left-held = A OR left arrow, right-held = D OR right arrow.
REQ-027 SHALL, with ARROW_KEYS_EN undefined, ignore every terminating byte reached via EXT or EXT_BRK and still return to IDLE; no arrow flags exist.

Verification
REQ-028 SHALL cover: strobe 1C, then F0 1C -> move_left 1 from the cycle after 1C, 0 from the cycle after the second 1C.
REQ-029 SHALL cover: 1C held, then 23 -> move_left and move_right both 0; then F0 1C -> move_right 1.
REQ-030 SHALL cover, with FIRE_COOLDOWN = 10: 29, F0 29, 29 within 10 cycles, F0 29, 29 after 12 cycles -> exactly two fire pulses, the middle press discarded.
REQ-031 SHALL cover: 29 repeated 5 times with no break -> exactly one fire pulse.
REQ-032 SHALL cover: 4D, F0 4D -> pause 1; 1C -> move_left stays 0; 4D, F0 4D -> pause 0 and move_left 1.
REQ-033 SHALL cover: E0 6B with ARROW_KEYS_EN -> move_left 1; without it -> move_left 0; E0 then iRST pulse then 6B -> no effect in either build.
